jk_reg_bank: RTL

Parametrised bank of WIDTH edge-triggered JK flip-flops with a synchronous active-low reset, clock enable and parallel load. A mode select reuses the same JK cells as an independent JK register, a synchronous up or down counter, or a serial-in shift register. It is the clocked, multi-bit successor to the single-bit level-sensitive JK latch. It is the standard register primitive for lab designs that need JK semantics.

---
 rtl/jk_reg_bank.sv | 103 ++++++++++
 1 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: bank of WIDTH edge-triggered JK flip-flops with synchronous
// active-low reset, clock enable and parallel load. The mode select reuses the
// same JK cells as an independent JK register, an up/down counter or a
// serial-in shift register. Each mode only decides what J and K each cell sees.
module jk_reg_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             tc_reg;
    logic             tc_next;

    // Effective J/K seen by each cell after mode steering.
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;

    // Per-cell toggle conditions for counting and data for shifting.
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;
    logic [WIDTH-1:0] shift_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            if (gi == 0) begin : g_lsb
                // The LSB always toggles when counting and takes ser_in when shifting.
                assign up_tog[gi]  = 1'b1;
                assign dn_tog[gi]  = 1'b1;
                assign shift_d[gi] = ser_in;
            end else begin : g_upper
                // A counter bit toggles when every lower bit is about to carry
                // (all ones going up) or borrow (all zeros going down).
                assign up_tog[gi]  = &q_reg[gi-1:0];
                assign dn_tog[gi]  = ~|q_reg[gi-1:0];
                assign shift_d[gi] = q_reg[gi-1];
            end

            // Counting drives J=K=toggle; shifting drives J=d, K=~d so the cell
            // behaves as a D flip-flop.
            assign j_eff[gi] = (mode == MODE_JK)   ? j[gi]      :
                               (mode == MODE_UP)   ? up_tog[gi] :
                               (mode == MODE_DOWN) ? dn_tog[gi] :
                                                     shift_d[gi];
            assign k_eff[gi] = (mode == MODE_JK)   ? k[gi]      :
                               (mode == MODE_UP)   ? up_tog[gi] :
                               (mode == MODE_DOWN) ? dn_tog[gi] :
                                                     ~shift_d[gi];

            // Characteristic equation of the JK cell.
            assign q_next[gi] = (j_eff[gi] & ~q_reg[gi]) | (~k_eff[gi] & q_reg[gi]);
        end
    endgenerate

    // Terminal-count / shift-out flag computed from the pre-edge state.
    always_comb begin
        tc_next = 1'b0;
        case (mode)
            MODE_UP:    tc_next = &q_reg;
            MODE_DOWN:  tc_next = ~|q_reg;
            MODE_SHIFT: tc_next = q_reg[WIDTH-1];
            default:    tc_next = 1'b0;
        endcase
    end

    // State update: reset beats load, load beats enable, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg  <= '0;
            tc_reg <= 1'b0;
        end else if (load) begin
            q_reg  <= load_val;
            tc_reg <= 1'b0;
        end else if (en) begin
            q_reg  <= q_next;
            tc_reg <= tc_next;
        end
    end

    // qbar comes straight from the state register so it never lags q.
    assign q    = q_reg;
    assign qbar = ~q_reg;
    assign tc   = tc_reg;

endmodule
